// File: rtl/foo_link_responder.sv
// Responder end of the foo single-outstanding request/response link.
// Serves reads/writes to a local DEPTH-word register array after a fixed LATENCY wait.
module foo_link_responder #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam bit                SHORT    = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_wcnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_rsp_done;
    logic                w_enter_resp;
    logic                w_op_write;
    logic [ADDR_W-1:0]   w_op_addr;
    logic [DATA_W-1:0]   w_op_wdata;
    logic                w_op_err;
    logic [DATA_W-1:0]   w_mem_rd;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_ready is 1 only in IDLE; rsp_valid is 1 only in RESP, so the two never overlap.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rsp_done   = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (SHORT) begin
                        w_next_state = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == CNT_W'(1)) begin
                    w_next_state = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // With LATENCY==1 the RESP entry edge is the accept edge, so the live request is used.
    always_comb begin
        w_op_write = (r_state == IDLE) ? req_write : r_write;
        w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
        w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
        w_op_err   = ({1'b0, w_op_addr} >= DEPTH_W);
        w_mem_rd   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_op_addr == ADDR_W'(i)) begin
                w_mem_rd = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wcnt  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wcnt  <= CNT_LOAD;
            end else if (r_state == WAIT) begin
                r_wcnt <= r_wcnt - CNT_W'(1);
            end
            if (w_enter_resp) begin
                r_err   <= w_op_err;
                r_rdata <= (w_op_write || w_op_err) ? '0 : w_mem_rd;
            end else if (w_rsp_done) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_enter_resp && w_op_write && !w_op_err && (w_op_addr == ADDR_W'(i))) begin
                    r_mem[i] <= w_op_wdata;
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_foo_link_responder.sv
// Self-checking bench for foo_link_responder: a LATENCY=2 instance and a LATENCY=1 instance,
// both checked against an array-based model of the register file.
module tb_foo_link_responder;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 12;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic rst;

    logic              req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, busy;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata, rsp_rdata;

    logic              l1_req_valid, l1_req_ready, l1_req_write, l1_rsp_valid, l1_rsp_ready, l1_rsp_err, l1_busy;
    logic [ADDR_W-1:0] l1_req_addr;
    logic [DATA_W-1:0] l1_req_wdata, l1_rsp_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] model_mem [2][16];
    logic [DATA_W-1:0] exp_q [$];
    logic              exp_err_q [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    foo_link_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    foo_link_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_rdata(l1_rsp_rdata),
        .rsp_err(l1_rsp_err), .busy(l1_busy)
    );

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                model_mem[k][i] = '0;
    endfunction

    // A transaction either errors (address past the array), writes, or reads.
    function automatic void model_apply(input int inst, input logic w, input logic [ADDR_W-1:0] a,
                                        input logic [DATA_W-1:0] d,
                                        output logic [DATA_W-1:0] rd, output logic er);
        int ai;
        ai = int'(a);
        if (ai >= DEPTH) begin
            er = 1'b1;
            rd = '0;
        end else if (w) begin
            er = 1'b0;
            rd = '0;
            model_mem[inst][ai] = d;
        end else begin
            er = 1'b0;
            rd = model_mem[inst][ai];
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Issues one request on the LATENCY=2 port with rsp_ready=1; starts and ends at a negedge.
    task automatic drive_txn(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             output logic [DATA_W-1:0] rd, output logic er, output int lat);
        int cnt;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = $urandom;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000 || rsp_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_l2: got rdy/vld/err/busy=%b rdata=%h, required 1000 rdata=0",
                     {req_ready, rsp_valid, rsp_err, busy}, rsp_rdata);
        end
        n_vec++;
        if ({l1_req_ready, l1_rsp_valid, l1_rsp_err, l1_busy} !== 4'b1000 || l1_rsp_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_l1: got rdy/vld/err/busy=%b rdata=%h, required 1000 rdata=0",
                     {l1_req_ready, l1_rsp_valid, l1_rsp_err, l1_busy}, l1_rsp_rdata);
        end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] rd, er_d;
        logic er, ee;
        int lat;
        model_apply(0, 1'b1, 4'd3, 32'hDEADBEEF, er_d, ee);
        drive_txn(1'b1, 4'd3, 32'hDEADBEEF, rd, er, lat);
        n_vec++;
        if (lat !== LAT || rd !== er_d || er !== ee) begin
            n_err++;
            $display("FAIL write3: got lat=%0d rdata=%h err=%b, required lat=%0d rdata=%h err=%b",
                     lat, rd, er, LAT, er_d, ee);
        end
        model_apply(0, 1'b0, 4'd3, '0, er_d, ee);
        drive_txn(1'b0, 4'd3, 32'h0, rd, er, lat);
        n_vec++;
        if (lat !== LAT || rd !== 32'hDEADBEEF || rd !== er_d || er !== 1'b0) begin
            n_err++;
            $display("FAIL read3: got lat=%0d rdata=%h err=%b, required lat=%0d rdata=deadbeef err=0",
                     lat, rd, er, LAT);
        end
    endtask

    task automatic test_errors();
        logic [DATA_W-1:0] rd, exp_rd;
        logic er, exp_er;
        int lat;
        logic              ops_w [2] = '{1'b0, 1'b1};
        logic [ADDR_W-1:0] ops_a [2] = '{4'd12, 4'd15};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            model_apply(0, ops_w[i], ops_a[i], $urandom, exp_rd, exp_er);
            drive_txn(ops_w[i], ops_a[i], $urandom, rd, er, lat);
            n_vec++;
            if (er !== 1'b1 || er !== exp_er || rd !== '0 || lat !== LAT) begin
                n_err++;
                $display("FAIL err_addr%0d: got err=%b rdata=%h lat=%0d, required err=1 rdata=0 lat=%0d",
                         ops_a[i], er, rd, lat, LAT);
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            model_apply(0, 1'b0, ADDR_W'(a), '0, exp_rd, exp_er);
            drive_txn(1'b0, ADDR_W'(a), '0, rd, er, lat);
            n_vec++;
            if (rd !== exp_rd || er !== exp_er) begin
                n_err++;
                $display("FAIL err_readback%0d: got rdata=%h err=%b, required rdata=%h err=%b",
                         a, rd, er, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_hold();
        logic [DATA_W-1:0] rd, exp_rd, d;
        logic er, exp_er;
        int lat;
        d = $urandom;
        model_apply(0, 1'b1, 4'd7, d, exp_rd, exp_er);
        drive_txn(1'b1, 4'd7, d, rd, er, lat);
        model_apply(0, 1'b0, 4'd7, '0, exp_rd, exp_er);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== exp_rd || rsp_err !== exp_er) begin
                n_err++;
                $display("FAIL hold%0d: got vld=%b rdy=%b rdata=%h err=%b, required vld=1 rdy=0 rdata=%h err=%b",
                         i, rsp_valid, req_ready, rsp_rdata, rsp_err, exp_rd, exp_er);
            end
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'b1;
            req_addr  = 4'd9;
            req_wdata = $urandom | 32'h1;
            if (i < 5) @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: got rdy=%b vld=%b rdata=%h busy=%b, required rdy=1 vld=0 rdata=0 busy=0",
                     req_ready, rsp_valid, rsp_rdata, busy);
        end
        model_apply(0, 1'b0, 4'd9, '0, exp_rd, exp_er);
        drive_txn(1'b0, 4'd9, '0, rd, er, lat);
        n_vec++;
        if (rd !== exp_rd || er !== exp_er) begin
            n_err++;
            $display("FAIL hold_ignored: got addr9 rdata=%h, required %h", rd, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] rd, exp_rd;
        logic er, exp_er, acc;
        int idx, resp, last_acc, lat;
        idx = 0; resp = 0; last_acc = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd0; req_wdata = 32'h0;
        for (int cyc = 0; cyc < 80 && (idx < DEPTH || resp < DEPTH); cyc++) begin
            if (rsp_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0 || rsp_rdata !== exp_q[0] || rsp_err !== exp_err_q[0]) begin
                    n_err++;
                    $display("FAIL b2b_rsp%0d: got rdata=%h err=%b, required rdata=0 err=0", resp, rsp_rdata, rsp_err);
                end
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
                resp++;
            end
            acc = (req_ready === 1'b1) && (idx < DEPTH);
            if (acc) begin
                if (idx > 0) begin
                    n_vec++;
                    if (cyc - last_acc !== LAT + 1) begin
                        n_err++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", idx, cyc - last_acc, LAT + 1);
                    end
                end
                last_acc = cyc;
                model_apply(0, 1'b1, req_addr, req_wdata, exp_rd, exp_er);
                exp_q.push_back(exp_rd);
                exp_err_q.push_back(exp_er);
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < DEPTH) begin
                    req_addr  = ADDR_W'(idx);
                    req_wdata = 32'(idx) * 32'h11;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        n_vec++;
        if (resp !== DEPTH || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d responses, required %0d", resp, DEPTH);
        end
        exp_q.delete();
        exp_err_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            model_apply(0, 1'b0, ADDR_W'(a), '0, exp_rd, exp_er);
            drive_txn(1'b0, ADDR_W'(a), '0, rd, er, lat);
            n_vec++;
            if (rd !== 32'(a) * 32'h11 || rd !== exp_rd || er !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_readback%0d: got rdata=%h err=%b, required rdata=%h err=0", a, rd, er, 32'(a) * 32'h11);
            end
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] rd, exp_rd, d;
        logic [ADDR_W-1:0] a;
        logic er, exp_er, w;
        int lat;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ADDR_W'($urandom_range(0, 15));
            d = $urandom;
            model_apply(0, w, a, d, exp_rd, exp_er);
            exp_q.push_back(exp_rd);
            exp_err_q.push_back(exp_er);
            drive_txn(w, a, d, rd, er, lat);
            exp_rd = exp_q.pop_front();
            exp_er = exp_err_q.pop_front();
            n_vec++;
            if (rd !== exp_rd || er !== exp_er || lat !== LAT) begin
                n_err++;
                $display("FAIL rand%0d w=%b a=%0d: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, w, a, rd, er, lat, exp_rd, exp_er, LAT);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] rd, exp_rd;
        logic er, exp_er;
        int lat;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd1; req_wdata = 32'h5; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got vld=%b rdy=%b busy=%b err=%b, required vld=0 rdy=1 busy=0 err=0",
                     rsp_valid, req_ready, busy, rsp_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_apply(0, 1'b0, 4'd1, '0, exp_rd, exp_er);
        drive_txn(1'b0, 4'd1, '0, rd, er, lat);
        n_vec++;
        if (rd !== 32'h0 || rd !== exp_rd || er !== exp_er) begin
            n_err++;
            $display("FAIL reset_mid_read: got rdata=%h err=%b, required rdata=0 err=0", rd, er);
        end
    endtask

    task automatic test_latency1();
        logic              ops_w [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [ADDR_W-1:0] ops_a [5] = '{4'd2, 4'd2, 4'd13, 4'd2, 4'd11};
        logic [DATA_W-1:0] exp_rd;
        logic exp_er, acc;
        int idx, resp, last_acc;
        idx = 0; resp = 0; last_acc = -10;
        l1_rsp_ready = 1'b1;
        l1_req_valid = 1'b1; l1_req_write = ops_w[0]; l1_req_addr = ops_a[0]; l1_req_wdata = $urandom;
        for (int cyc = 0; cyc < 40 && resp < 5; cyc++) begin
            if (l1_rsp_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0 || cyc !== last_acc + 1 ||
                    l1_rsp_rdata !== exp_q[0] || l1_rsp_err !== exp_err_q[0]) begin
                    n_err++;
                    $display("FAIL l1_rsp%0d: got cycle=%0d rdata=%h err=%b, required cycle=%0d and model data",
                             resp, cyc, l1_rsp_rdata, l1_rsp_err, last_acc + 1);
                end
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
                resp++;
            end
            acc = (l1_req_ready === 1'b1) && (idx < 5);
            if (acc) begin
                if (idx > 0) begin
                    n_vec++;
                    if (cyc - last_acc !== 2) begin
                        n_err++;
                        $display("FAIL l1_spacing%0d: got %0d cycles, required 2", idx, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                model_apply(1, l1_req_write, l1_req_addr, l1_req_wdata, exp_rd, exp_er);
                exp_q.push_back(exp_rd);
                exp_err_q.push_back(exp_er);
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 5) begin
                    l1_req_write = ops_w[idx];
                    l1_req_addr  = ops_a[idx];
                    l1_req_wdata = $urandom;
                end else begin
                    l1_req_valid = 1'b0;
                end
            end
        end
        n_vec++;
        if (resp !== 5) begin
            n_err++;
            $display("FAIL l1_count: got %0d responses, required 5", resp);
        end
        exp_q.delete();
        exp_err_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0; l1_req_wdata = '0; l1_rsp_ready = 1'b1;
        model_reset();
        test_reset();
        test_write_read();
        test_errors();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
